inst_axi_rd_bridge: RTL and testbench

Converts the instruction-side sram-like request interface driven by the fetch stage into AXI4 read transactions toward the system bus. Every request is read-only, in order, and single-beat. Several requests may be outstanding, so the fetch stage can issue the next PC while an earlier instruction is still returning. The block sits between the fetch stage and the CPU-top AXI read arbiter. The AW, W and B channels are tied off at CPU top and are not part of this block.

---
 rtl/inst_axi_rd_bridge.sv | 115 +++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch sram-like to AXI4 read bridge: single-beat, in-order reads
// with up to MAX_OUTST accepted-but-not-returned requests.
module inst_axi_rd_bridge #(
    parameter int          MAX_OUTST = 2,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addrok,
    output logic        inst_sram_dataok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bus_err
);

    localparam int             CW      = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTST);

    logic          ar_pend_q, ar_pend_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [2:0]    arsize_q, arsize_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          bus_err_q, bus_err_d;
    logic          accept_s;
    logic          r_hs_s;
    logic          unused_s;

    // Writes are never issued from fetch and the single-ID, single-beat bus
    // makes rid/rlast redundant.
    assign unused_s = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast};

    assign accept_s = inst_sram_req && !ar_pend_q && (outst_q < MAX_CNT);
    assign rready   = (outst_q != {CW{1'b0}});
    assign r_hs_s   = rvalid && rready;

    assign inst_sram_addrok = accept_s;
    assign inst_sram_dataok = r_hs_s;
    assign inst_sram_rdata  = rdata;

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;
    assign arvalid = ar_pend_q;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign bus_err = bus_err_q;

    // Next-state logic for the AR register, outstanding counter and error flag.
    always_comb begin
        ar_pend_d = ar_pend_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        outst_d   = outst_q;
        bus_err_d = bus_err_q | (r_hs_s && (rresp != 2'b00));

        if (accept_s) begin
            ar_pend_d = 1'b1;
            araddr_d  = inst_sram_addr;
            arsize_d  = {1'b0, inst_sram_size};
        end else if (ar_pend_q && arready) begin
            ar_pend_d = 1'b0;
        end else begin
            ar_pend_d = ar_pend_q;
        end

        // A return in the same cycle as an accept leaves the count unchanged.
        case ({accept_s, r_hs_s})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_pend_q <= 1'b0;
            araddr_q  <= 32'd0;
            arsize_q  <= 3'd0;
            outst_q   <= {CW{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            ar_pend_q <= ar_pend_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            outst_q   <= outst_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge: directed test-plan steps then
// randomized traffic, checked against a transaction-queue reference model.
module tb_inst_axi_rd_bridge;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_s, wr_s;
    logic [1:0]  size_s;
    logic [31:0] addr_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;
    logic        addrok_s, dataok_s;
    logic [31:0] irdata_s;
    logic [3:0]  arid_s;
    logic [31:0] araddr_s;
    logic [7:0]  arlen_s;
    logic [2:0]  arsize_s;
    logic [1:0]  arburst_s, arlock_s;
    logic [3:0]  arcache_s;
    logic [2:0]  arprot_s;
    logic        arvalid_s, arready_s;
    logic [3:0]  rid_s;
    logic [31:0] rdata_s;
    logic [1:0]  rresp_s;
    logic        rlast_s, rvalid_s, rready_s, bus_err_s;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(.MAX_OUTST(MAXO), .AXI_ID(4'd0)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(req_s), .inst_sram_wr(wr_s), .inst_sram_size(size_s),
        .inst_sram_addr(addr_s), .inst_sram_wstrb(wstrb_s), .inst_sram_wdata(wdata_s),
        .inst_sram_addrok(addrok_s), .inst_sram_dataok(dataok_s), .inst_sram_rdata(irdata_s),
        .arid(arid_s), .araddr(araddr_s), .arlen(arlen_s), .arsize(arsize_s),
        .arburst(arburst_s), .arlock(arlock_s), .arcache(arcache_s), .arprot(arprot_s),
        .arvalid(arvalid_s), .arready(arready_s),
        .rid(rid_s), .rdata(rdata_s), .rresp(rresp_s), .rlast(rlast_s),
        .rvalid(rvalid_s), .rready(rready_s), .bus_err(bus_err_s)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
    } req_t;

    // Model: requests accepted but not yet on AR, and requests sent but not returned.
    req_t ar_q[$];
    req_t rd_q[$];
    logic m_err;
    logic m_acc;
    int   total  = 0;
    int   passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input logic rq, input logic [31:0] ad, input logic [1:0] sz,
                       input logic ary, input logic rv, input logic [31:0] rd,
                       input logic [1:0] rr);
        int   outst;
        logic e_acc, e_rr, e_arv, e_dok;
        req_t t;
        req_s = rq; addr_s = ad; size_s = sz; arready_s = ary;
        rvalid_s = rv; rdata_s = rd; rresp_s = rr;
        wr_s = 1'($urandom_range(0, 1)); wstrb_s = 4'($urandom); wdata_s = $urandom;
        rid_s = 4'($urandom); rlast_s = 1'($urandom_range(0, 1));
        #1;
        outst = ar_q.size() + rd_q.size();
        e_acc = rq && (ar_q.size() == 0) && (outst < MAXO);
        e_rr  = (outst != 0);
        e_arv = (ar_q.size() != 0);
        e_dok = rv && e_rr;
        check("addrok", {31'd0, addrok_s}, {31'd0, e_acc});
        check("arvalid", {31'd0, arvalid_s}, {31'd0, e_arv});
        check("rready", {31'd0, rready_s}, {31'd0, e_rr});
        check("dataok", {31'd0, dataok_s}, {31'd0, e_dok});
        check("bus_err", {31'd0, bus_err_s}, {31'd0, m_err});
        if (e_arv) begin
            check("araddr", araddr_s, ar_q[0].addr);
            check("arsize", {29'd0, arsize_s}, {29'd0, 1'b0, ar_q[0].size});
        end
        if (e_dok) check("inst_rdata", irdata_s, rd);
        @(posedge clk);
        if (e_dok) begin
            t = rd_q.pop_front();
            if (rr != 2'b00) m_err = 1'b1;
        end
        if (e_arv && ary) begin
            t = ar_q.pop_front();
            rd_q.push_back(t);
        end
        if (e_acc) begin
            t.addr = ad; t.size = sz;
            ar_q.push_back(t);
        end
        m_acc = e_acc;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_s = 1'b0; rvalid_s = 1'b0; arready_s = 1'b0;
        @(posedge clk);
        ar_q.delete(); rd_q.delete(); m_err = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("rst_arvalid", {31'd0, arvalid_s}, 32'd0);
        check("rst_araddr", araddr_s, 32'd0);
        check("rst_arsize", {29'd0, arsize_s}, 32'd0);
        check("rst_rready", {31'd0, rready_s}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err_s}, 32'd0);
        check("rst_addrok", {31'd0, addrok_s}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic        rv;
        reset = 1'b1; req_s = 1'b0; wr_s = 1'b0; size_s = 2'd0; addr_s = 32'd0;
        wstrb_s = 4'd0; wdata_s = 32'd0; arready_s = 1'b0; rid_s = 4'd0;
        rdata_s = 32'd0; rresp_s = 2'd0; rlast_s = 1'b0; rvalid_s = 1'b0;
        m_err = 1'b0; m_acc = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check("arlen", {24'd0, arlen_s}, 32'd0);
        check("arburst", {30'd0, arburst_s}, 32'd1);
        check("arid", {28'd0, arid_s}, 32'd0);
        check("arlock_cache_prot", {23'd0, arlock_s, arcache_s, arprot_s}, 32'd0);

        // 1: single fetch, data returned 3 cycles after the AR handshake
        cyc(1'b1, 32'hBFC0_0000, 2'd2, 1'b1, 1'b0, 32'd0, 2'd0);
        check("t1_accept", {31'd0, m_acc}, 32'd1);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, 2'd0);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, 2'd0);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, 2'd0);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b1, 32'h3C1D_0000, 2'd0);
        check("t1_idle_rready", {31'd0, rready_s}, 32'd0);

        // 2: back-to-back requests held until accepted
        a = 32'hBFC0_0000;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, a, 2'd2, 1'b1, (i == 5), 32'h1111_0000 + i, 2'd0);
            if (m_acc) a = a + 32'd4;
        end
        check("t2_third_accepted", a, 32'hBFC0_000C);
        while (rd_q.size() != 0 || ar_q.size() != 0)
            cyc(1'b0, 32'd0, 2'd0, 1'b1, rd_q.size() != 0, 32'h2222_0000, 2'd0);

        // 3: AR stall for 5 cycles
        cyc(1'b1, 32'h0000_1000, 2'd2, 1'b0, 1'b0, 32'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h0000_2000, 2'd2, 1'b0, 1'b0, 32'd0, 2'd0);
            check("t3_araddr_held", araddr_s, 32'h0000_1000);
        end
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, 2'd0);
        check("t3_ar_done", {31'd0, arvalid_s}, 32'd0);

        // 4: accept and return in the same cycle with one outstanding
        cyc(1'b1, 32'h0000_3000, 2'd2, 1'b0, 1'b1, 32'hCAFE_0001, 2'd0);
        check("t4_rready_after", {31'd0, rready_s}, 32'd1);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, 2'd0);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b1, 32'hCAFE_0002, 2'd0);

        // 5: error response then 10 good beats
        cyc(1'b1, 32'h0000_4000, 2'd2, 1'b1, 1'b0, 32'd0, 2'd0);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, 2'd0);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10);
        check("t5_bus_err_set", {31'd0, bus_err_s}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h0000_5000 + 32'(i * 4), 2'd2, 1'b1, 1'b0, 32'd0, 2'd0);
            cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, 2'd0);
            cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b1, 32'hA000_0000 + i, 2'd0);
        end
        check("t5_bus_err_sticky", {31'd0, bus_err_s}, 32'd1);

        // 6: reset with two outstanding and AR pending
        cyc(1'b1, 32'h0000_6000, 2'd2, 1'b1, 1'b0, 32'd0, 2'd0);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, 2'd0);
        cyc(1'b1, 32'h0000_6004, 2'd2, 1'b0, 1'b0, 32'd0, 2'd0);
        check("t6_pre_arvalid", {31'd0, arvalid_s}, 32'd1);
        do_reset();
        cyc(1'b1, 32'h0000_7000, 2'd1, 1'b1, 1'b0, 32'd0, 2'd0);
        check("t6_post_accept", {31'd0, m_acc}, 32'd1);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, 2'd0);
        cyc(1'b0, 32'd0, 2'd0, 1'b1, 1'b1, 32'h7777_7777, 2'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rv = (rd_q.size() != 0) && ($urandom_range(0, 2) != 0);
            cyc(1'($urandom_range(0, 1)), {$urandom, 2'b00} >> 2 << 2, 2'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), rv, $urandom,
                ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
        end
        while (rd_q.size() != 0 || ar_q.size() != 0)
            cyc(1'b0, 32'd0, 2'd0, 1'b1, rd_q.size() != 0, $urandom, 2'd0);
        check("final_rready", {31'd0, rready_s}, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
